// File: rtl/nn_frame_loader.sv
// Frame loader for nn_core: unpacks 32-bit words into byte-wide pixel writes, starts the core,
// and latches its classification (or a timeout error) as sticky status for software.
module nn_frame_loader #(
    parameter int unsigned N_IN           = 784,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        abort,
    output logic        pix_we,
    output logic [9:0]  pix_addr,
    output logic [7:0]  pix_data,
    output logic        core_start,
    input  logic        core_done,
    input  logic [3:0]  core_predicted,
    output logic [3:0]  result,
    output logic        result_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {StLoad, StUnpack, StStart, StWait} state_e;

    localparam logic [9:0]  LastPix  = 10'(N_IN - 1);
    localparam logic [19:0] WaitLast = 20'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [31:0] word_q;
    logic [1:0]  byte_idx_q;
    logic [9:0]  pix_cnt_q;
    logic [19:0] wait_cnt_q;
    logic        pix_we_q;
    logic [9:0]  pix_addr_q;
    logic [7:0]  pix_data_q;
    logic        core_start_q;
    logic [3:0]  result_q;
    logic        result_valid_q;
    logic        err_q;
    logic [1:0]  next_idx;

    assign next_idx = byte_idx_q + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StLoad;
            word_q         <= '0;
            byte_idx_q     <= '0;
            pix_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            pix_we_q       <= 1'b0;
            pix_addr_q     <= '0;
            pix_data_q     <= '0;
            core_start_q   <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            pix_we_q     <= 1'b0;
            core_start_q <= 1'b0;
            if (abort) begin
                state_q    <= StLoad;
                pix_cnt_q  <= '0;
                byte_idx_q <= '0;
                wait_cnt_q <= '0;
                err_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StLoad: begin
                        if (s_valid) begin
                            word_q         <= s_data;
                            byte_idx_q     <= '0;
                            result_valid_q <= 1'b0;
                            err_q          <= 1'b0;
                            // First write of the word is issued straight from the input bus.
                            pix_we_q       <= 1'b1;
                            pix_addr_q     <= pix_cnt_q;
                            pix_data_q     <= s_data[7:0];
                            state_q        <= StUnpack;
                        end
                    end
                    StUnpack: begin
                        byte_idx_q <= next_idx;
                        if (byte_idx_q == 2'd3) begin
                            if (pix_cnt_q == LastPix) begin
                                core_start_q <= 1'b1;
                                state_q      <= StStart;
                            end else begin
                                pix_cnt_q <= pix_cnt_q + 10'd1;
                                state_q   <= StLoad;
                            end
                        end else begin
                            pix_cnt_q  <= pix_cnt_q + 10'd1;
                            pix_we_q   <= 1'b1;
                            pix_addr_q <= pix_cnt_q + 10'd1;
                            pix_data_q <= word_q[8*next_idx +: 8];
                        end
                    end
                    StStart: begin
                        wait_cnt_q <= '0;
                        state_q    <= StWait;
                    end
                    StWait: begin
                        // Done takes precedence over a timeout in the same cycle.
                        if (core_done) begin
                            result_q       <= core_predicted;
                            result_valid_q <= 1'b1;
                            pix_cnt_q      <= '0;
                            state_q        <= StLoad;
                        end else if (wait_cnt_q == WaitLast) begin
                            err_q     <= 1'b1;
                            pix_cnt_q <= '0;
                            state_q   <= StLoad;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 20'd1;
                        end
                    end
                    default: state_q <= StLoad;
                endcase
            end
        end
    end

    assign s_ready      = (state_q == StLoad);
    assign busy         = (state_q != StLoad);
    assign pix_we       = pix_we_q;
    assign pix_addr     = pix_addr_q;
    assign pix_data     = pix_data_q;
    assign core_start   = core_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Directed bench for nn_frame_loader: full frames, backpressure, timeout, abort and reset-in-WAIT.
module tb_nn_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        abort;
    logic        pix_we;
    logic [9:0]  pix_addr;
    logic [7:0]  pix_data;
    logic        core_start;
    logic        core_done;
    logic [3:0]  core_predicted;
    logic [3:0]  result;
    logic        result_valid;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    nn_frame_loader #(.N_IN(784), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .abort(abort), .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
        .core_start(core_start), .core_done(core_done), .core_predicted(core_predicted),
        .result(result), .result_valid(result_valid), .busy(busy), .err(err)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_addr = 0;
    logic [7:0] seed = 8'd0;
    int n_start = 0;
    int start_cyc = -1;
    int last_wr_cyc = -1;
    int core_delay = 2;
    int cd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance to the falling edge, run the core model and the write monitor.
    task automatic tick();
        @(negedge clk);
        cyc++;
        core_done = 1'b0;
        if (cd != 0) begin
            cd--;
            if (cd == 0) core_done = 1'b1;
        end
        if (core_start) begin
            n_start++;
            start_cyc = cyc;
            if (core_delay != 0) cd = core_delay;
        end
        if (pix_we) begin
            chk("wr_addr", 32'(pix_addr), exp_addr);
            chk("wr_data", 32'(pix_data), (exp_addr + int'(seed)) & 255);
            if (pix_addr == 10'd783) last_wr_cyc = cyc;
            exp_addr++;
        end
        chk("ready_when_busy", 32'(s_ready & (busy | pix_we | core_start)), 0);
    endtask

    function automatic logic [31:0] mk_word(input int k, input logic [7:0] sd);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = 8'(4 * k + i + int'(sd));
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic send_word(input logic [31:0] w, output int acc_cyc);
        bit ok = 1'b0;
        acc_cyc = -1;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (s_ready && !abort) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            tick();
        end
        s_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int nwords, input logic [7:0] sd, input bit gaps,
                              output int acc0, output logic [1:0] first_flags);
        int a;
        seed = sd;
        exp_addr = 0;
        n_start = 0;
        acc0 = -1;
        first_flags = 2'b00;
        for (int k = 0; k < nwords; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            send_word(mk_word(k, sd), a);
            if (k == 0) begin
                acc0 = a;
                first_flags = {result_valid, err};
            end
        end
    endtask

    // which=0 waits for result_valid, which=1 for err; returns the cycle it was first seen.
    task automatic wait_flag(input bit which, output int at);
        at = -1;
        for (int i = 0; i < 60 && at < 0; i++) begin
            tick();
            if ((which ? err : result_valid) === 1'b1) at = cyc;
        end
        if (at < 0) chk(which ? "err_timeout" : "rv_timeout", 0, 1);
    endtask

    initial begin
        int acc0;
        int at;
        logic [1:0] ff;

        rst_n = 1'b0;
        s_valid = 1'b1;
        s_data = 32'hdead_beef;
        abort = 1'b0;
        core_done = 1'b0;
        core_predicted = 4'd7;

        // Reset held with a word offered
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", 32'({pix_we, pix_addr, pix_data, core_start, result,
                                      result_valid, busy, err}), 0);
        end
        s_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(s_ready), 1);
        chk("no_write_after_reset", 32'(pix_we), 0);

        // Full frame, core answers 7 two cycles after start
        send_frame(196, 8'h00, 1'b0, acc0, ff);
        wait_flag(1'b0, at);
        chk("full_writes", exp_addr, 784);
        chk("full_starts", n_start, 1);
        chk("start_after_last", start_cyc, last_wr_cyc + 1);
        chk("frame_cycles", last_wr_cyc - acc0 + 1, 980);
        chk("rv_latency", at, start_cyc + 3);
        chk("full_result", 32'(result), 7);
        chk("full_rv", 32'(result_valid), 1);
        chk("full_busy", 32'(busy), 0);

        // Backpressure: random source gaps
        core_predicted = 4'd3;
        send_frame(196, 8'h55, 1'b1, acc0, ff);
        chk("bp_first_clears_rv", 32'(ff[1]), 0);
        wait_flag(1'b0, at);
        chk("bp_writes", exp_addr, 784);
        chk("bp_starts", n_start, 1);
        chk("bp_result", 32'(result), 3);

        // Timeout: core never answers; 16 WAIT cycles, then the flag
        core_delay = 0;
        send_frame(196, 8'h11, 1'b0, acc0, ff);
        wait_flag(1'b1, at);
        chk("timeout_latency", at, start_cyc + 17);
        chk("timeout_busy", 32'(busy), 0);
        chk("timeout_result_kept", 32'(result), 3);
        chk("timeout_rv", 32'(result_valid), 0);

        // Done on the terminal-count cycle wins over the timeout
        core_delay = 16;
        core_predicted = 4'd9;
        send_frame(196, 8'h44, 1'b0, acc0, ff);
        chk("accept_clears_err", 32'(ff[0]), 0);
        wait_flag(1'b0, at);
        chk("terminal_rv_at", at, start_cyc + 17);
        chk("terminal_err", 32'(err), 0);
        chk("terminal_result", 32'(result), 9);

        // Abort while idle with a word offered: not accepted, result_valid kept
        s_valid = 1'b1;
        s_data = 32'h0102_0304;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_no_accept", 32'(pix_we), 0);
        chk("abort_keeps_rv", 32'(result_valid), 1);
        tick();
        chk("abort_no_accept_late", 32'(pix_we), 0);

        // Second timeout, then an idle abort clears err
        core_delay = 0;
        send_frame(196, 8'h66, 1'b0, acc0, ff);
        wait_flag(1'b1, at);
        chk("timeout2_err", 32'(err), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_clears_err", 32'(err), 0);

        // Abort mid-frame after word 50, then a fresh frame must restart at address 0
        core_delay = 2;
        core_predicted = 4'd5;
        send_frame(50, 8'h22, 1'b0, acc0, ff);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_partial_writes", exp_addr, 198);
        chk("abort_idle", 32'({pix_we, busy, s_ready}), 32'b001);
        chk("abort_result_kept", 32'(result), 9);
        send_frame(196, 8'h22, 1'b0, acc0, ff);
        wait_flag(1'b0, at);
        chk("after_abort_writes", exp_addr, 784);
        chk("after_abort_result", 32'(result), 5);
        chk("after_abort_err", 32'(err), 0);

        // Reset while in WAIT; the late core_done must be ignored
        core_delay = 8;
        send_frame(196, 8'h33, 1'b0, acc0, ff);
        for (int i = 0; i < 20 && n_start == 0; i++) tick();
        chk("rw_started", n_start, 1);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rw_rv", 32'(result_valid), 0);
        chk("rw_busy", 32'(busy), 0);
        chk("rw_result", 32'(result), 0);
        chk("rw_ready", 32'(s_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
